// File: rtl/layer5_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : layer5_pkg
//  Description : Shared constants, FSM state encoding and tap-index helper
//                for the layer-4 result reader / layer-5 window datapath.
//                DATA_W is the layer-4 output pixel length (128 bits).
//  Revision    : 1.0 - initial release
// ============================================================================
package layer5_pkg;

    localparam int IN_WIDTH  = 12;
    localparam int K         = 3;
    localparam int DATA_W    = 128;
    localparam int OUT_WIDTH = IN_WIDTH - K + 1;
    localparam int NTAPS     = K * K;
    localparam int KW        = $clog2(K);
    localparam int TAP_W     = $clog2(NTAPS);
    localparam int COORD_W   = 8;
    localparam int ADDR_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Flat tap position of window element (kr, kc), row-major.
    function automatic logic [TAP_W-1:0] tap_index(input logic [KW-1:0] kr,
                                                   input logic [KW-1:0] kc);
        return TAP_W'(kr) * TAP_W'(K) + TAP_W'(kc);
    endfunction

endpackage
`default_nettype wire

// File: rtl/layer5_window_regs.sv
`default_nettype none
// ============================================================================
//  Module      : layer5_window_regs
//  Description : K x K x DATA_W window register bank with per-tap write,
//                synchronous clear and (LAYER5_WINDOW_REUSE_EN only) a
//                one-column left shift used on same-row window steps.
//  Revision    : 1.0 - initial release
// ============================================================================
module layer5_window_regs
    import layer5_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [TAP_W-1:0]        wr_tap,
    input  logic [DATA_W-1:0]       wr_data,
`ifdef LAYER5_WINDOW_REUSE_EN
    input  logic                    shift_en,
`endif
    output logic [NTAPS*DATA_W-1:0] window
);

    logic [DATA_W-1:0] r_taps [NTAPS];

    // Tap storage: clear, column shift (kc+1 -> kc) or single-tap write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < NTAPS; t++) begin
                r_taps[t] <= '0;
            end
        end
`ifdef LAYER5_WINDOW_REUSE_EN
        else if (shift_en) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    r_taps[r*K + c] <= r_taps[r*K + c + 1];
                end
            end
        end
`endif
        else if (wr_en) begin
            r_taps[wr_tap] <= wr_data;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NTAPS; g++) begin : g_flat
            assign window[g*DATA_W +: DATA_W] = r_taps[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/layer4_result_reader.sv
`default_nettype none
// ============================================================================
//  Module      : layer4_result_reader
//  Description : Walks the 12x12 layer-4 result store, assembles 3x3 windows
//                and hands them to layer 5 over valid/ready.
//                Optional macro LAYER5_WINDOW_REUSE_EN: reuse two columns on
//                same-row steps so only the new column is fetched.
//  Revision    : 1.0 - initial release
// ============================================================================
module layer4_result_reader
    import layer5_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic [ADDR_W-1:0]       read_row_addr,
    output logic [ADDR_W-1:0]       read_col_addr,
    output logic                    layer4_result_read_signal,
    input  logic [DATA_W-1:0]       layer4_result_output,
    output logic [NTAPS*DATA_W-1:0] window_out,
    output logic                    window_valid,
    input  logic                    window_ready,
    output logic [COORD_W-1:0]      out_row,
    output logic [COORD_W-1:0]      out_col,
    output logic                    busy,
    output logic                    done
);

`ifdef LAYER5_WINDOW_REUSE_EN
    localparam logic [KW-1:0] c_step_kc = KW'(K - 1);
`else
    localparam logic [KW-1:0] c_step_kc = '0;
`endif

    state_t              r_state;
    state_t              w_state_next;
    logic [KW-1:0]       r_kr;
    logic [KW-1:0]       r_kc;
    logic [COORD_W-1:0]  r_out_row;
    logic [COORD_W-1:0]  r_out_col;
    logic                w_last_read;
    logic                w_handshake;
    logic                w_last_window;
    logic                w_row_wrap;
    logic                w_fetch;

    assign w_fetch       = (r_state == ST_FETCH);
    assign w_last_read   = (r_kr == KW'(K - 1)) && (r_kc == KW'(K - 1));
    assign w_handshake   = (r_state == ST_HOLD) && window_ready;
    assign w_row_wrap    = (r_out_col == COORD_W'(OUT_WIDTH - 1));
    assign w_last_window = w_row_wrap && (r_out_row == COORD_W'(OUT_WIDTH - 1));

    assign out_row = r_out_row;
    assign out_col = r_out_col;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        w_state_next              = r_state;
        layer4_result_read_signal = 1'b0;
        read_row_addr             = '0;
        read_col_addr             = '0;
        window_valid              = 1'b0;
        busy                      = 1'b0;
        done                      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                busy                      = 1'b1;
                layer4_result_read_signal = 1'b1;
                read_row_addr             = ADDR_W'(r_out_row) + ADDR_W'(r_kr);
                read_col_addr             = ADDR_W'(r_out_col) + ADDR_W'(r_kc);
                if (w_last_read) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                busy         = 1'b1;
                window_valid = 1'b1;
                if (w_handshake) begin
                    w_state_next = w_last_window ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Window coordinates and in-window fetch counters (kr inner, kc outer).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_kr      <= '0;
            r_kc      <= '0;
            r_out_row <= '0;
            r_out_col <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_kr      <= '0;
                        r_kc      <= '0;
                        r_out_row <= '0;
                        r_out_col <= '0;
                    end
                end
                ST_FETCH: begin
                    if (!w_last_read) begin
                        if (r_kr == KW'(K - 1)) begin
                            r_kr <= '0;
                            r_kc <= r_kc + 1'b1;
                        end else begin
                            r_kr <= r_kr + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_handshake && !w_last_window) begin
                        r_kr <= '0;
                        if (w_row_wrap) begin
                            r_out_col <= '0;
                            r_out_row <= r_out_row + 1'b1;
                            r_kc      <= '0;
                        end else begin
                            r_out_col <= r_out_col + 1'b1;
                            r_kc      <= c_step_kc;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef LAYER5_WINDOW_REUSE_EN
    logic w_shift;
    assign w_shift = w_handshake && !w_last_window && !w_row_wrap;
`endif

    layer5_window_regs u_window_regs (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (w_fetch),
        .wr_tap   (tap_index(r_kr, r_kc)),
        .wr_data  (layer4_result_output),
`ifdef LAYER5_WINDOW_REUSE_EN
        .shift_en (w_shift),
`endif
        .window   (window_out)
    );

endmodule
`default_nettype wire

// File: tb/tb_layer4_result_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_layer4_result_reader
//  Description : Scoreboard bench for layer4_result_reader with a store model
//                holding pixel(r,c) = r*16 + c.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_layer4_result_reader;
    import layer5_pkg::*;

`ifdef LAYER5_WINDOW_REUSE_EN
    localparam int c_exp_done = 461;
`else
    localparam int c_exp_done = 1001;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [ADDR_W-1:0]       read_row_addr;
    logic [ADDR_W-1:0]       read_col_addr;
    logic                    layer4_result_read_signal;
    logic [DATA_W-1:0]       layer4_result_output;
    logic [NTAPS*DATA_W-1:0] window_out;
    logic                    window_valid;
    logic                    window_ready;
    logic [COORD_W-1:0]      out_row;
    logic [COORD_W-1:0]      out_col;
    logic                    busy;
    logic                    done;

    layer4_result_reader dut (
        .clk                       (clk),
        .rst                       (rst),
        .start                     (start),
        .read_row_addr             (read_row_addr),
        .read_col_addr             (read_col_addr),
        .layer4_result_read_signal (layer4_result_read_signal),
        .layer4_result_output      (layer4_result_output),
        .window_out                (window_out),
        .window_valid              (window_valid),
        .window_ready              (window_ready),
        .out_row                   (out_row),
        .out_col                   (out_col),
        .busy                      (busy),
        .done                      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]                      row;
        logic [7:0]                      col;
        logic [NTAPS-1:0][DATA_W-1:0]    taps;
    } exp_t;

    exp_t sb[$];
    int   rd_rows[$];
    int   rd_cols[$];
    int   n_checks    = 0;
    int   n_fail      = 0;
    int   cycle       = 0;
    int   first_valid = -1;
    int   done_cycle  = -1;
    int   oob         = 0;

    function automatic logic [DATA_W-1:0] pix(input int r, input int c);
        return DATA_W'(r * 16 + c);
    endfunction

    // Store model: address sampled on the falling edge, data held for the cycle.
    always @(negedge clk) begin
        layer4_result_output <= pix(int'(read_row_addr), int'(read_col_addr));
    end

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_pass();
        exp_t e;
        for (int r = 0; r < OUT_WIDTH; r++) begin
            for (int c = 0; c < OUT_WIDTH; c++) begin
                e.row = 8'(r);
                e.col = 8'(c);
                for (int kr = 0; kr < K; kr++) begin
                    for (int kc = 0; kc < K; kc++) begin
                        e.taps[kr*K + kc] = pix(r + kr, c + kc);
                    end
                end
                sb.push_back(e);
            end
        end
    endtask

    task automatic monitor();
        exp_t e;
        int   bad;
        if (window_valid && first_valid < 0) first_valid = cycle;
        if (done && done_cycle < 0) done_cycle = cycle;
        if (layer4_result_read_signal) begin
            rd_rows.push_back(int'(read_row_addr));
            rd_cols.push_back(int'(read_col_addr));
            if (read_row_addr > ADDR_W'(IN_WIDTH - 1) || read_col_addr > ADDR_W'(IN_WIDTH - 1)) oob++;
        end
        if (window_valid && window_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                check("out_row", out_row, e.row);
                check("out_col", out_col, e.col);
                for (int t = 0; t < NTAPS; t++) begin
                    check($sformatf("tap%0d_w%0d_%0d", t, e.row, e.col),
                          window_out[t*DATA_W +: DATA_W], e.taps[t]);
                end
                if (out_row == 0 && out_col == 0)
                    check("w00_tap4", window_out[4*DATA_W +: DATA_W], 'h11);
                if (out_row == 1 && out_col == 0) begin
                    check("wrap_nreads", rd_rows.size(), 9);
                    bad = 0;
                    foreach (rd_rows[i])
                        if (rd_rows[i] != 1 + i % 3 || rd_cols[i] != i / 3) bad++;
                    check("wrap_addr_bad", bad, 0);
                end
                if (out_row == 2 && out_col == 5) begin
                    bad = 0;
`ifdef LAYER5_WINDOW_REUSE_EN
                    check("step_nreads", rd_rows.size(), 3);
                    foreach (rd_rows[i])
                        if (rd_rows[i] != 2 + i || rd_cols[i] != 7) bad++;
`else
                    check("step_nreads", rd_rows.size(), 9);
                    foreach (rd_rows[i])
                        if (rd_rows[i] != 2 + i % 3 || rd_cols[i] != 5 + i / 3) bad++;
`endif
                    check("step_addr_bad", bad, 0);
                    check("step_tap0", window_out[DATA_W-1:0], pix(2, 5));
                end
            end
            rd_rows.delete();
            rd_cols.delete();
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic begin_pass();
        push_pass();
        rd_rows.delete();
        rd_cols.delete();
        first_valid = -1;
        done_cycle  = -1;
        start       = 1'b1;
        cycle       = 0;
        tick();
        start       = 1'b0;
    endtask

    task automatic finish_pass(input string tag);
        for (int i = 0; i < 3000 && done_cycle < 0; i++) tick();
        check({tag, "_first_valid"}, first_valid, 10);
        check({tag, "_done_cycle"}, done_cycle, c_exp_done);
        check({tag, "_sb_empty"}, sb.size(), 0);
        tick();
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_oob"}, oob, 0);
    endtask

    logic [NTAPS*DATA_W-1:0] w_saved;
    logic [7:0]              row_saved;
    logic [7:0]              col_saved;
    bit                      bp_done;
    bit                      hit;

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        window_ready = 1'b1;
        repeat (3) tick();
        check("rst_valid", window_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd", layer4_result_read_signal, 0);
        check("rst_row_addr", read_row_addr, 0);
        check("rst_col_addr", read_col_addr, 0);
        check("rst_out_row", out_row, 0);
        check("rst_out_col", out_col, 0);
        check("rst_window", |window_out, 0);
        rst = 1'b0;
        tick();

        // Pass A: free-running, with stray start pulses in FETCH and HOLD.
        begin_pass();
        check("busy_c1", busy, 1);
        while (cycle < 3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        while (cycle < 10) tick();
        check("valid_c10", window_valid, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_pass("passA");

        // Pass B: backpressure on (3,5), then reset in the middle of (5,5).
        begin_pass();
        bp_done = 1'b0;
        hit     = 1'b0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            tick();
            if (!bp_done && window_valid && out_row == 3 && out_col == 5) begin
                bp_done      = 1'b1;
                window_ready = 1'b0;
                w_saved      = window_out;
                row_saved    = out_row;
                col_saved    = out_col;
                repeat (20) begin
                    tick();
                    check("bp_window_stable", (window_out == w_saved) ? 1 : 0, 1);
                    check("bp_row", out_row, row_saved);
                    check("bp_col", out_col, col_saved);
                    check("bp_valid", window_valid, 1);
                    check("bp_rd", layer4_result_read_signal, 0);
                end
                window_ready = 1'b1;
            end
            if (layer4_result_read_signal && out_row == 5 && out_col == 5 && rd_rows.size() >= 1)
                hit = 1'b1;
        end
        check("midfetch_reached", hit, 1);
        check("bp_seen", bp_done, 1);
        rst = 1'b1;
        tick();
        check("mrst_valid", window_valid, 0);
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_rd", layer4_result_read_signal, 0);
        check("mrst_row_addr", read_row_addr, 0);
        check("mrst_col_addr", read_col_addr, 0);
        check("mrst_out_row", out_row, 0);
        check("mrst_out_col", out_col, 0);
        check("mrst_window", |window_out, 0);
        rst = 1'b0;
        sb.delete();
        tick();
        check("idle_after_rst", busy, 0);

        // Pass C: restart after the mid-pass reset.
        begin_pass();
        finish_pass("passC");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
